// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH     = 64;
  localparam int unsigned IMEM_ADDR_W    = 6;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  // Host/memory side drives the stream and observes the writes.
  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; strobes word_full on the last byte.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);

  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d = '0;
    end else if (in_valid) begin
      idx_d  = idx_q + 1'b1;
      // Shift right so the first byte of a word ends up in the low lane.
      word_d = {in_byte, word_q[31:8]};
    end
  end

  assign word_full = in_valid && !clear && (idx_q == IdxW'(BYTES_PER_WORD - 1));
  assign word      = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length/data/checksum frame and writes it into instruction memory,
// holding the CPU stalled until a frame has been loaded and verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           cpu_stall,
  output logic           busy,
  output logic           done,
  output logic           error
);

  // One extra bit so a count of DEPTH is representable.
  localparam int unsigned CntW = ADDR_W + 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] n_q, n_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      csum_q, csum_d;

  logic ready_q, ready_d;
  logic we_q, we_d;
  logic stall_q, stall_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic        accept;
  logic        len_bad;
  logic        pk_clear;
  logic        pk_valid;
  logic        pk_full;
  logic [31:0] pk_word;

  assign accept  = bus.byte_valid && ready_q;
  assign len_bad = (bus.byte_data == 8'd0) || (32'(bus.byte_data) > DEPTH);

  imem_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .in_valid  (pk_valid),
    .in_byte   (bus.byte_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    pk_clear = 1'b0;
    pk_valid = 1'b0;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d  = StLen;
          cnt_d    = '0;
          csum_d   = '0;
          pk_clear = 1'b1;
        end
      end
      StLen: begin
        if (accept) begin
          if (len_bad) begin
            state_d = StErr;
          end else begin
            n_d     = bus.byte_data[CntW-1:0];
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          pk_valid = 1'b1;
          csum_d   = csum_q + bus.byte_data;
          if (pk_full) state_d = StWrite;
        end
      end
      StWrite: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == n_q) ? StCsum : StData;
      end
      StCsum: begin
        if (accept) state_d = (bus.byte_data == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered images of the next state.
    ready_d = (state_d == StLen) || (state_d == StData) || (state_d == StCsum);
    we_d    = (state_d == StWrite);
    busy_d  = ready_d || we_d;
    done_d  = (state_d == StDone);
    error_d = (state_d == StErr);
    stall_d = !done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      stall_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = cnt_q[ADDR_W-1:0];
  assign bus.imem_wdata = pk_word;
  assign cpu_stall      = stall_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule
